hazard_unit: RTL and testbench

Parametrised hazard-detection and forwarding controller for the 5+ stage pipeline, sitting beside the control unit and driving the datapath's pcWrite, ifidWrite, ifidFlush, bubble and forwarding-mux selects. Generalises the fixed two-source forwarding and single-cycle load-use stall to a configurable number of post-EX forwarding stages and a configurable load latency. Also supplies forwarding selects to the ID-stage branch comparator, and handles multi-cycle data-memory freezes.

---
 rtl/hazard_unit.sv | 152 +++++++++++++++
 tb/tb_hazard_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Hazard detection and forwarding control for the EX operands and the ID branch comparator.
// Latency: selects and stall/flush are combinational from inputs, FSM state and cnt; mem_busy freezes state.
// Optional build macro HAZARD_STATS_EN adds saturating stall_cycles / flush_count outputs.
module hazard_unit #(
    parameter int REG_AW     = 5,
    parameter int FWD_STAGES = 2,
    parameter int LOAD_LAT   = 1,
    parameter int FSEL_W     = $clog2(FWD_STAGES + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [REG_AW-1:0]            id_rs,
    input  logic [REG_AW-1:0]            id_rt,
    input  logic                         id_uses_rs,
    input  logic                         id_uses_rt,
    input  logic                         id_is_branch,
    input  logic                         br_taken,
    input  logic [REG_AW-1:0]            ex_rs,
    input  logic [REG_AW-1:0]            ex_rt,
    input  logic                         ex_reg_write,
    input  logic                         ex_mem_read,
    input  logic [REG_AW-1:0]            ex_write_reg,
    input  logic [FWD_STAGES-1:0]        st_reg_write,
    input  logic [FWD_STAGES-1:0]        st_mem_read,
    input  logic [FWD_STAGES*REG_AW-1:0] st_write_reg,
    input  logic                         mem_busy,
    output logic                         pc_write,
    output logic                         ifid_write,
    output logic                         ifid_flush,
    output logic                         idex_bubble,
    output logic                         pipe_freeze,
    output logic [FSEL_W-1:0]            forward_a,
    output logic [FSEL_W-1:0]            forward_b,
    output logic [FSEL_W-1:0]            id_fwd_a,
    output logic [FSEL_W-1:0]            id_fwd_b
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]                  stall_cycles,
    output logic [15:0]                  flush_count
`endif
);

    typedef enum logic [0:0] {RUN, STALL} state_t;

    state_t     state;
    logic [2:0] cnt;
    logic [2:0] haz_n;
    logic       stall;
    logic       dep;

    // Scan from the far stage inward so the nearest eligible producer overwrites.
    function automatic logic [FSEL_W-1:0] fwd_sel(
        input logic [REG_AW-1:0]            r,
        input logic [FWD_STAGES-1:0]        we,
        input logic [FWD_STAGES-1:0]        mr,
        input logic [FWD_STAGES*REG_AW-1:0] wr
    );
        logic [FSEL_W-1:0] s;
        s = '0;
        for (int i = FWD_STAGES - 1; i >= 0; i--) begin
            if (r != '0 && we[i] && wr[i*REG_AW +: REG_AW] == r && (!mr[i] || i >= LOAD_LAT))
                s = FSEL_W'(i + 1);
        end
        return s;
    endfunction

    assign dep = ex_reg_write &&
                 ((id_uses_rs && id_rs != '0 && id_rs == ex_write_reg) ||
                  (id_uses_rt && id_rt != '0 && id_rt == ex_write_reg));

    always_comb begin
        haz_n = 3'd0;
        if (dep && ex_mem_read)
            haz_n = id_is_branch ? 3'(LOAD_LAT + 1) : 3'(LOAD_LAT);
        else if (dep && id_is_branch)
            haz_n = 3'd1;
        // A load still short of its data stage cannot yet feed the ID comparator.
        for (int i = 0; i < LOAD_LAT; i++) begin
            if (id_is_branch && st_reg_write[i] && st_mem_read[i] &&
                ((id_uses_rs && id_rs != '0 && st_write_reg[i*REG_AW +: REG_AW] == id_rs) ||
                 (id_uses_rt && id_rt != '0 && st_write_reg[i*REG_AW +: REG_AW] == id_rt)) &&
                3'(LOAD_LAT - i) > haz_n)
                haz_n = 3'(LOAD_LAT - i);
        end
    end

    assign stall = (state == STALL) || (haz_n != 3'd0);

    always_comb begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_freeze = 1'b0;
        forward_a   = '0;
        forward_b   = '0;
        id_fwd_a    = '0;
        id_fwd_b    = '0;
        if (rst) begin
            forward_a = fwd_sel(ex_rs, st_reg_write, st_mem_read, st_write_reg);
            forward_b = fwd_sel(ex_rt, st_reg_write, st_mem_read, st_write_reg);
            id_fwd_a  = fwd_sel(id_rs, st_reg_write, st_mem_read, st_write_reg);
            id_fwd_b  = fwd_sel(id_rt, st_reg_write, st_mem_read, st_write_reg);
            if (mem_busy) begin
                pipe_freeze = 1'b1;
            end else if (stall) begin
                idex_bubble = 1'b1;
            end else begin
                pc_write   = 1'b1;
                ifid_write = 1'b1;
                ifid_flush = br_taken;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else if (!mem_busy) begin
            case (state)
                RUN: begin
                    if (haz_n > 3'd1) begin
                        state <= STALL;
                        cnt   <= haz_n - 3'd1;
                    end
                end
                STALL: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1)
                        state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= 16'd0;
            flush_count  <= 16'd0;
        end else begin
            if (stall && !mem_busy && stall_cycles != 16'hFFFF)
                stall_cycles <= stall_cycles + 16'd1;
            if (ifid_flush && flush_count != 16'hFFFF)
                flush_count <= flush_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, ex_write_reg;
    logic        id_uses_rs, id_uses_rt, id_is_branch, br_taken;
    logic        ex_reg_write, ex_mem_read, mem_busy;
    logic [2:0]  st_reg_write, st_mem_read;
    logic [14:0] st_write_reg;

    logic        o1_pc, o1_ifw, o1_flush, o1_bub, o1_pf;
    logic [1:0]  o1_fa, o1_fb, o1_ia, o1_ib;
    logic        o2_pc, o2_ifw, o2_flush, o2_bub, o2_pf;
    logic [1:0]  o2_fa, o2_fb, o2_ia, o2_ib;
`ifdef HAZARD_STATS_EN
    logic [15:0] s1_stall, s1_flush, s2_stall, s2_flush;
`endif

    int checks   = 0;
    int failures = 0;
    int rem1     = 0;
    int rem2     = 0;

    hazard_unit #(.REG_AW(5), .FWD_STAGES(2), .LOAD_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_is_branch(id_is_branch), .br_taken(br_taken),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_write_reg(ex_write_reg),
        .st_reg_write(st_reg_write[1:0]), .st_mem_read(st_mem_read[1:0]),
        .st_write_reg(st_write_reg[9:0]), .mem_busy(mem_busy),
        .pc_write(o1_pc), .ifid_write(o1_ifw), .ifid_flush(o1_flush), .idex_bubble(o1_bub),
        .pipe_freeze(o1_pf), .forward_a(o1_fa), .forward_b(o1_fb), .id_fwd_a(o1_ia), .id_fwd_b(o1_ib)
`ifdef HAZARD_STATS_EN
        , .stall_cycles(s1_stall), .flush_count(s1_flush)
`endif
    );

    hazard_unit #(.REG_AW(5), .FWD_STAGES(3), .LOAD_LAT(2)) dut2 (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_is_branch(id_is_branch), .br_taken(br_taken),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_write_reg(ex_write_reg),
        .st_reg_write(st_reg_write), .st_mem_read(st_mem_read),
        .st_write_reg(st_write_reg), .mem_busy(mem_busy),
        .pc_write(o2_pc), .ifid_write(o2_ifw), .ifid_flush(o2_flush), .idex_bubble(o2_bub),
        .pipe_freeze(o2_pf), .forward_a(o2_fa), .forward_b(o2_fb), .id_fwd_a(o2_ia), .id_fwd_b(o2_ib)
`ifdef HAZARD_STATS_EN
        , .stall_cycles(s2_stall), .flush_count(s2_flush)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Nearest post-EX stage that legally holds the value of r, 1-based; 0 means register file.
    function automatic int m_fwd(input int fs, input int ll, input logic [4:0] r);
        int sel;
        sel = 0;
        for (int i = 0; i < fs; i++) begin
            if (sel == 0 && r != 5'd0 && st_reg_write[i] && st_write_reg[i*5 +: 5] == r &&
                (!st_mem_read[i] || i >= ll))
                sel = i + 1;
        end
        return sel;
    endfunction

    function automatic bit m_reads(input logic [4:0] d);
        return d != 5'd0 && ((id_uses_rs && id_rs == d) || (id_uses_rt && id_rt == d));
    endfunction

    // Stall length demanded by the ID instruction in a fresh (non-stalled) cycle.
    function automatic int m_haz(input int fs, input int ll);
        int n;
        n = 0;
        if (ex_reg_write && m_reads(ex_write_reg)) begin
            if (ex_mem_read) n = id_is_branch ? ll + 1 : ll;
            else if (id_is_branch) n = 1;
        end
        for (int i = 0; i < ll && i < fs; i++)
            if (id_is_branch && st_reg_write[i] && st_mem_read[i] &&
                m_reads(st_write_reg[i*5 +: 5]) && (ll - i) > n)
                n = ll - i;
        return n;
    endfunction

    task automatic model_cmp(input int fs, input int ll, input int rem_in, input logic [4:0] act,
                             input logic [1:0] fa, input logic [1:0] fb,
                             input logic [1:0] ia, input logic [1:0] ib,
                             input string tag, output int rem_out);
        int n;
        logic [4:0] e;
        n = m_haz(fs, ll);
        if (!rst)          e = 5'b00000;
        else if (mem_busy) e = 5'b00001;
        else if (rem_in > 0 || n > 0) e = 5'b00010;
        else               e = {2'b11, br_taken, 2'b00};
        chk({tag, "_ctl"}, 32'(act), 32'(e));
        chk({tag, "_fwd_a"}, 32'(fa), rst ? m_fwd(fs, ll, ex_rs) : 0);
        chk({tag, "_fwd_b"}, 32'(fb), rst ? m_fwd(fs, ll, ex_rt) : 0);
        chk({tag, "_id_fwd_a"}, 32'(ia), rst ? m_fwd(fs, ll, id_rs) : 0);
        chk({tag, "_id_fwd_b"}, 32'(ib), rst ? m_fwd(fs, ll, id_rt) : 0);
        rem_out = rem_in;
        if (!rst)               rem_out = 0;
        else if (!mem_busy) begin
            if (rem_in > 0)     rem_out = rem_in - 1;
            else if (n > 0)     rem_out = n - 1;
        end
    endtask

    always @(negedge clk) begin
        model_cmp(2, 1, rem1, {o1_pc, o1_ifw, o1_flush, o1_bub, o1_pf},
                  o1_fa, o1_fb, o1_ia, o1_ib, "d1", rem1);
        model_cmp(3, 2, rem2, {o2_pc, o2_ifw, o2_flush, o2_bub, o2_pf},
                  o2_fa, o2_fb, o2_ia, o2_ib, "d2", rem2);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0; id_is_branch = 0; br_taken = 0;
        ex_rs = 0; ex_rt = 0; ex_reg_write = 0; ex_mem_read = 0; ex_write_reg = 0;
        st_reg_write = 0; st_mem_read = 0; st_write_reg = 0; mem_busy = 0;
    endtask

    task automatic set_st(input int i, input logic we, input logic mr, input logic [4:0] r);
        st_reg_write[i] = we;
        st_mem_read[i]  = mr;
        st_write_reg[i*5 +: 5] = r;
    endtask

    task automatic ex_load_dep(input logic [4:0] r, input logic br);
        ex_reg_write = 1; ex_mem_read = 1; ex_write_reg = r;
        id_rs = r; id_uses_rs = 1; id_is_branch = br;
    endtask

    int cnt;
    int fz;

    initial begin
        rst = 0;
        clr();
        step();
        step(); ex_rs = 3; set_st(0, 1, 0, 3); #2;
        chk("rst_pc_write", 32'(o1_pc), 0);
        chk("rst_forward_a", 32'(o1_fa), 0);

        step(); rst = 1; clr(); #2;
        chk("run_pc_write", 32'(o1_pc), 1);
        chk("run_ifid_write", 32'(o1_ifw), 1);

        step(); clr(); ex_rs = 3; set_st(0, 1, 0, 3); set_st(1, 1, 0, 3); #2;
        chk("fwd_nearest", 32'(o1_fa), 1);
        step(); clr(); ex_rs = 3; set_st(1, 1, 0, 3); #2;
        chk("fwd_wb_only", 32'(o1_fa), 2);
        step(); clr(); set_st(0, 1, 0, 0); #2;
        chk("fwd_reg0", 32'(o1_fa), 0);
        step(); clr(); ex_rt = 6; set_st(0, 1, 1, 6); set_st(1, 1, 0, 6); #2;
        chk("fwd_skip_early_load_d1", 32'(o1_fb), 2);
        chk("fwd_skip_early_load_d2", 32'(o2_fb), 2);
        step(); clr(); ex_rs = 7; id_rs = 7; set_st(2, 1, 0, 7); #2;
        chk("fwd_stage2_d2", 32'(o2_fa), 3);
        chk("id_fwd_stage2_d2", 32'(o2_ia), 3);
        chk("fwd_stage2_absent_d1", 32'(o1_fa), 0);

        // Load-use with single-cycle load latency.
        step(); clr(); ex_load_dep(4, 0); #2;
        chk("lu_bubble", 32'(o1_bub), 1);
        chk("lu_pc_write", 32'(o1_pc), 0);
        chk("lu_ifid_write", 32'(o1_ifw), 0);
        step(); clr(); id_rs = 4; id_uses_rs = 1; set_st(0, 1, 1, 4); #2;
        chk("lu_release", 32'(o1_pc), 1);
        step(); clr(); ex_rs = 4; set_st(1, 1, 1, 4); #2;
        chk("lu_fwd_wb", 32'(o1_fa), 2);
        step(); clr(); step(); clr();

        // Load-use with two-cycle load latency.
        step(); clr(); ex_load_dep(8, 0); #2; cnt = int'(o2_bub);
        repeat (4) begin step(); clr(); #2; cnt += int'(o2_bub); end
        chk("ll2_loaduse_cycles", cnt, 2);

        // Branch on load result: three stall cycles, then forwarded from the last stage.
        step(); clr(); ex_load_dep(5, 1); #2; cnt = int'(o2_bub);
        step(); clr(); id_is_branch = 1; id_rs = 5; id_uses_rs = 1; set_st(0, 1, 1, 5); br_taken = 1; #2;
        cnt += int'(o2_bub);
        chk("br_taken_while_stalled", 32'(o2_flush), 0);
        step(); clr(); id_is_branch = 1; id_rs = 5; id_uses_rs = 1; set_st(1, 1, 1, 5); #2;
        cnt += int'(o2_bub);
        step(); clr(); id_is_branch = 1; id_rs = 5; id_uses_rs = 1; set_st(2, 1, 1, 5); #2;
        cnt += int'(o2_bub);
        chk("br_load_id_fwd", 32'(o2_ia), 3);
        chk("br_load_cycles", cnt, 3);

        step(); clr(); br_taken = 1; #2;
        chk("flush_d1", 32'(o1_flush), 1);
        chk("flush_d2", 32'(o2_flush), 1);
        step(); clr(); #2;
        chk("flush_one_cycle", 32'(o1_flush), 0);

        // Freeze in the middle of a stall holds the remaining count.
        step(); clr(); ex_load_dep(9, 0); #2; cnt = int'(o2_bub); fz = 0;
        repeat (4) begin step(); clr(); mem_busy = 1; #2; fz += int'(o2_pf); cnt += int'(o2_bub); end
        repeat (3) begin step(); clr(); #2; cnt += int'(o2_bub); end
        chk("freeze_cycles", fz, 4);
        chk("freeze_stall_total", cnt, 2);

        step(); clr(); ex_load_dep(10, 0); mem_busy = 1; #2;
        chk("busy_with_hazard_freeze", 32'(o1_pf), 1);
        chk("busy_with_hazard_no_bubble", 32'(o1_bub), 0);
        step(); mem_busy = 0; #2;
        chk("busy_hazard_retried", 32'(o1_bub), 1);
        step(); clr(); step(); step();

        // Reset pulse aborts a stall asynchronously.
        step(); clr(); ex_load_dep(11, 1);
        step(); clr(); #2;
        chk("pre_reset_bubble", 32'(o2_bub), 1);
        rst = 0; #1;
        chk("async_reset_pc_write", 32'(o2_pc), 0);
        chk("async_reset_bubble", 32'(o2_bub), 0);
        step();
        step(); rst = 1; #2;
        chk("post_reset_pc_write", 32'(o2_pc), 1);
        chk("post_reset_bubble", 32'(o2_bub), 0);
`ifdef HAZARD_STATS_EN
        chk("stats_stall_reset", 32'(s2_stall), 0);
        chk("stats_flush_reset", 32'(s2_flush), 0);
`endif
        step(); step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
